// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch stage with single outstanding request and IF/ID register
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        ifid_valid,
    output logic [31:0] ifid_pc,
    output logic [31:0] ifid_instr
);

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t      state;
    logic [31:0] fetch_pc;
    logic [31:0] req_pc;
    logic        drop;
    logic [31:0] buffer;

    // Request lines follow the state register directly so the address is valid in the same cycle.
    assign imem_req  = (state == S_REQ);
    assign imem_addr = fetch_pc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_REQ;
            fetch_pc   <= RESET_PC;
            req_pc     <= 32'h0;
            drop       <= 1'b0;
            buffer     <= 32'h0;
            ifid_valid <= 1'b0;
            ifid_pc    <= 32'h0;
            ifid_instr <= NOP;
        end else if (redirect_valid) begin
            fetch_pc   <= {redirect_pc[31:2], 2'b00};
            ifid_valid <= 1'b0;
            case (state)
                S_REQ: begin
                    if (imem_ready) begin
                        drop  <= 1'b1;
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem_rvalid) begin
                        drop  <= 1'b0;
                        state <= S_REQ;
                    end else begin
                        drop <= 1'b1;
                    end
                end
                default: state <= S_REQ;
            endcase
        end else begin
            // Bubble by default; a load below overrides it on the same edge.
            if (!stall) begin
                ifid_valid <= 1'b0;
            end
            case (state)
                S_REQ: begin
                    if (imem_ready) begin
                        req_pc   <= fetch_pc;
                        fetch_pc <= fetch_pc + 32'd4;
                        state    <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem_rvalid) begin
                        if (drop) begin
                            drop  <= 1'b0;
                            state <= S_REQ;
                        end else if (!stall) begin
                            ifid_valid <= 1'b1;
                            ifid_pc    <= req_pc;
                            ifid_instr <= imem_rdata;
                            state      <= S_REQ;
                        end else begin
                            buffer <= imem_rdata;
                            state  <= S_HOLD;
                        end
                    end
                end
                default: begin
                    if (!stall) begin
                        ifid_valid <= 1'b1;
                        ifid_pc    <= req_pc;
                        ifid_instr <= buffer;
                        state      <= S_REQ;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed self-checking bench for fetch_stage
module tb_fetch_stage;

    logic        clk;
    logic        rst;
    logic        rst2;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;

    logic        imem_req,   imem_req2;
    logic [31:0] imem_addr,  imem_addr2;
    logic        ifid_valid, ifid_valid2;
    logic [31:0] ifid_pc,    ifid_pc2;
    logic [31:0] ifid_instr, ifid_instr2;

    int checks;
    int failures;

    fetch_stage dut (
        .clk(clk), .rst(rst), .stall(stall),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .ifid_valid(ifid_valid), .ifid_pc(ifid_pc), .ifid_instr(ifid_instr)
    );

    fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
        .clk(clk), .rst(rst2), .stall(stall),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req(imem_req2), .imem_addr(imem_addr2), .imem_ready(imem_ready),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .ifid_valid(ifid_valid2), .ifid_pc(ifid_pc2), .ifid_instr(ifid_instr2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst = 1'b1;
        rst2 = 1'b1;
        stall = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = 32'h0;
        imem_ready = 1'b1;
        imem_rvalid = 1'b0;
        imem_rdata = 32'h0;

        #3;
        chk("rst_req",   {31'h0, imem_req},   32'h1);
        chk("rst_addr",  imem_addr,           32'h0);
        chk("rst_valid", {31'h0, ifid_valid}, 32'h0);
        chk("rst_pc",    ifid_pc,             32'h0);
        chk("rst_instr", ifid_instr,          32'h0000_0013);
        tick();
        rst = 1'b0;

        // Streaming fetch: request, 1-cycle response, bubble between instructions.
        tick();
        chk("s1_wait_req",  {31'h0, imem_req}, 32'h0);
        chk("s1_wait_addr", imem_addr,         32'h4);
        imem_rvalid = 1'b1; imem_rdata = 32'h0050_0093;
        tick();
        chk("s1_i0_valid", {31'h0, ifid_valid}, 32'h1);
        chk("s1_i0_pc",    ifid_pc,             32'h0);
        chk("s1_i0_instr", ifid_instr,          32'h0050_0093);
        chk("s1_req_addr", imem_addr,           32'h4);
        imem_rvalid = 1'b0;
        tick();
        chk("s1_bubble0", {31'h0, ifid_valid}, 32'h0);
        chk("s1_bubble0_pc", ifid_pc, 32'h0);
        imem_rvalid = 1'b1;
        tick();
        chk("s1_i1_valid", {31'h0, ifid_valid}, 32'h1);
        chk("s1_i1_pc",    ifid_pc,             32'h4);
        imem_rvalid = 1'b0;
        tick();
        chk("s1_bubble1", {31'h0, ifid_valid}, 32'h0);
        imem_rvalid = 1'b1;
        tick();
        chk("s1_i2_valid", {31'h0, ifid_valid}, 32'h1);
        chk("s1_i2_pc",    ifid_pc,             32'h8);

        // Stall while the response for 0xC arrives; stray rvalid in S_HOLD is ignored.
        imem_rvalid = 1'b0; stall = 1'b1;
        tick();
        chk("s2_hold_valid", {31'h0, ifid_valid}, 32'h1);
        chk("s2_hold_pc",    ifid_pc,             32'h8);
        imem_rvalid = 1'b1; imem_rdata = 32'hAAAA_0001;
        tick();
        chk("s2_hold_req", {31'h0, imem_req}, 32'h0);
        chk("s2_hold_instr", ifid_instr, 32'h0050_0093);
        imem_rdata = 32'h5555_0002;
        tick();
        chk("s2_hold2_pc", ifid_pc, 32'h8);
        imem_rvalid = 1'b0;
        tick();
        chk("s2_hold3_valid", {31'h0, ifid_valid}, 32'h1);
        chk("s2_hold3_req", {31'h0, imem_req}, 32'h0);
        stall = 1'b0;
        tick();
        chk("s2_rel_valid", {31'h0, ifid_valid}, 32'h1);
        chk("s2_rel_pc",    ifid_pc,             32'hC);
        chk("s2_rel_instr", ifid_instr,          32'hAAAA_0001);
        chk("s2_rel_addr",  imem_addr,           32'h10);

        // Redirect while waiting: pending response dropped.
        tick();
        chk("s3_wait_addr", imem_addr, 32'h14);
        redirect_valid = 1'b1; redirect_pc = 32'h100;
        tick();
        chk("s3_redir_valid", {31'h0, ifid_valid}, 32'h0);
        chk("s3_redir_addr", imem_addr, 32'h100);
        chk("s3_redir_req", {31'h0, imem_req}, 32'h0);
        redirect_valid = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        tick();
        chk("s3_drop_valid", {31'h0, ifid_valid}, 32'h0);
        chk("s3_drop_req", {31'h0, imem_req}, 32'h1);
        chk("s3_drop_addr", imem_addr, 32'h100);
        imem_rvalid = 1'b0;

        // Redirect coincident with acceptance; unaligned target is aligned.
        redirect_valid = 1'b1; redirect_pc = 32'h103;
        tick();
        chk("s4_align_addr", imem_addr, 32'h100);
        chk("s4_wait_req", {31'h0, imem_req}, 32'h0);
        redirect_valid = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h0BAD_0BAD;
        tick();
        chk("s4_drop_valid", {31'h0, ifid_valid}, 32'h0);
        chk("s4_next_req", {31'h0, imem_req}, 32'h1);
        chk("s4_next_addr", imem_addr, 32'h100);
        imem_rvalid = 1'b0;
        tick();
        imem_rvalid = 1'b1; imem_rdata = 32'h0000_0011;
        tick();
        chk("s4_new_valid", {31'h0, ifid_valid}, 32'h1);
        chk("s4_new_pc",    ifid_pc,             32'h100);
        chk("s4_new_instr", ifid_instr,          32'h0000_0011);

        // Redirect clears IF/ID even under stall.
        imem_rvalid = 1'b0; stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h40;
        tick();
        chk("s4_stall_redir_valid", {31'h0, ifid_valid}, 32'h0);
        chk("s4_stall_redir_addr", imem_addr, 32'h40);
        redirect_valid = 1'b0; stall = 1'b0; imem_rvalid = 1'b1;
        tick();
        imem_rvalid = 1'b0;

        // Wrap-around reset PC, then reset mid-request.
        rst2 = 1'b0;
        chk("s5_first_req", {31'h0, imem_req2}, 32'h1);
        chk("s5_first_addr", imem_addr2, 32'hFFFF_FFFC);
        tick();
        chk("s5_wrap_addr", imem_addr2, 32'h0);
        imem_rvalid = 1'b1; imem_rdata = 32'h1234_5678;
        tick();
        chk("s5_i0_pc",    ifid_pc2,    32'hFFFF_FFFC);
        chk("s5_i0_instr", ifid_instr2, 32'h1234_5678);
        chk("s5_second_req", {31'h0, imem_req2}, 32'h1);
        chk("s5_second_addr", imem_addr2, 32'h0);
        imem_rvalid = 1'b0;
        tick();
        chk("s5_wait_req", {31'h0, imem_req2}, 32'h0);
        #2 rst2 = 1'b1;
        #1;
        chk("s5_arst_valid", {31'h0, ifid_valid2}, 32'h0);
        chk("s5_arst_instr", ifid_instr2, 32'h0000_0013);
        chk("s5_arst_pc",    ifid_pc2,    32'h0);
        chk("s5_arst_addr",  imem_addr2,  32'hFFFF_FFFC);
        chk("s5_arst_req",   {31'h0, imem_req2}, 32'h1);
        #1 rst2 = 1'b0;
        imem_ready = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hFEED_FACE;
        tick();
        chk("s5_late_valid", {31'h0, ifid_valid2}, 32'h0);
        chk("s5_late_req", {31'h0, imem_req2}, 32'h1);
        chk("s5_late_addr", imem_addr2, 32'hFFFF_FFFC);
        imem_rvalid = 1'b0; imem_ready = 1'b1;
        tick();
        chk("s5_restart_addr", imem_addr2, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 SHALL have port stall, input, 1 bit: decode cannot accept; hold the IF/ID outputs.
REQ-005 SHALL have port redirect_valid, input, 1 bit: taken branch or jump from a later stage.
REQ-006 SHALL have port redirect_pc, input, 32 bits: the redirect target.
REQ-007 SHALL have port imem_req, output, 1 bit: fetch request valid.
REQ-008 SHALL have port imem_addr, output, 32 bits: fetch address.
REQ-009 SHALL have port imem_ready, input, 1 bit: memory accepts the request this cycle.
REQ-010 SHALL have port imem_rvalid, input, 1 bit: response data valid.
REQ-011 SHALL have port imem_rdata, input, 32 bits: fetched instruction word.
REQ-012 SHALL have port ifid_valid, output, 1 bit: IF/ID register holds a live instruction.
REQ-013 SHALL have port ifid_pc, output, 32 bits: PC of the instruction in IF/ID.
REQ-014 SHALL have port ifid_instr, output, 32 bits: instruction word driven to the decoder.

Function
REQ-015 SHALL keep fetch_pc, req_pc (PC of the outstanding request), a drop flag, a 32-bit hold buffer, and state S_REQ, S_WAIT or S_HOLD.
REQ-016 SHALL allow at most one outstanding memory request.
REQ-017 S_REQ SHALL drive imem_req=1 and imem_addr=fetch_pc; in S_WAIT and S_HOLD imem_req SHALL be 0 and imem_addr SHALL equal fetch_pc.
REQ-018 In S_REQ with imem_ready=1, the block SHALL set req_pc=fetch_pc, set fetch_pc=fetch_pc+4 (modulo 2^32; 32'hFFFF_FFFC wraps to 0), and go to S_WAIT.
REQ-019 In S_WAIT with imem_rvalid=1, drop=0 and stall=0, IF/ID SHALL load {1, req_pc, imem_rdata} on that edge and the state SHALL go to S_REQ; fetch latency from acceptance to ifid_valid is 1 cycle plus the memory latency.
REQ-020 In S_WAIT with imem_rvalid=1, drop=0 and stall=1, the block SHALL capture imem_rdata in the hold buffer and go to S_HOLD.
REQ-021 In S_HOLD with stall=0, IF/ID SHALL load {1, req_pc, buffer} and the state SHALL go to S_REQ.
REQ-022 In S_WAIT with imem_rvalid=1 and drop=1, the block SHALL discard the response, clear drop, and go to S_REQ.
REQ-023 With stall=1 and no redirect, ifid_valid, ifid_pc and ifid_instr SHALL hold their values.
REQ-024 With stall=0 and no instruction loaded that edge, ifid_valid SHALL become 0 (bubble), and ifid_pc and ifid_instr SHALL hold their values.
REQ-025 redirect_valid SHALL take priority over all other events and SHALL, on that edge, set fetch_pc={redirect_pc[31:2],2'b00} and ifid_valid=0, regardless of stall.
REQ-026 A redirect in S_REQ with imem_ready=1 SHALL set drop=1 and go to S_WAIT.
REQ-027 A redirect in S_REQ with imem_ready=0 SHALL stay in S_REQ.
REQ-028 A redirect in S_WAIT without imem_rvalid SHALL set drop=1.
REQ-029 A redirect in S_WAIT with imem_rvalid=1 SHALL discard the data, clear drop, and go to S_REQ.
REQ-030 A redirect in S_HOLD SHALL discard the buffer and go to S_REQ.
REQ-031 imem_rvalid SHALL be ignored in S_REQ and S_HOLD.

Reset
REQ-032 While rst=1, the block SHALL asynchronously set state=S_REQ, fetch_pc=RESET_PC, req_pc=0, drop=0, buffer=0, ifid_valid=0, ifid_pc=0, ifid_instr=32'h0000_0013 (NOP).
REQ-033 Reset asserted mid-request SHALL abandon the outstanding request, and no later response SHALL reach IF/ID until a new request is accepted.
REQ-034 On the first edge after rst deasserts, the block SHALL present imem_req=1 and imem_addr=RESET_PC.

Verification
REQ-035 Stimulus: reset, then imem_ready=1 always and 1-cycle rvalid with rdata=32'h00500093. Required: ifid = {1, 0x0, 0x00500093}, then pc 0x4, 0x8, with a bubble between each instruction.
REQ-036 Stimulus: stall=1 for 3 cycles while the response arrives. Required: S_HOLD is entered, IF/ID is unchanged, and after release IF/ID loads the buffered word with the correct req_pc.
REQ-037 Stimulus: redirect_valid=1, redirect_pc=0x100 while in S_WAIT. Required: the pending response is dropped, ifid_valid=0, and the next imem_addr is 0x100.
REQ-038 Stimulus: redirect on the same edge as imem_ready in S_REQ. Required: drop=1, the response for the old address never appears in IF/ID, and the next request is to the redirect target.
REQ-039 Stimulus: redirect_pc=0x103. Required: imem_addr is 0x100.
REQ-040 Stimulus: RESET_PC=32'hFFFF_FFFC. Required: second request address is 0x0; rst pulsed while in S_WAIT yields reset values immediately and a restart from RESET_PC.
